// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Bundles the operand, handshake, result and display signals of
//   serial_adder_ctrl. The master side (stimulus/board) drives SW, CIN,
//   START (and FLIP when MANUAL_PAGE_EN is defined). The slave side (the
//   controller) drives BUSY, DONE, LED, SLED0..SLED4 and dbg_state.
//
//   Handshake: START is level-sampled every clock. A low-to-high transition
//   is accepted only while BUSY=0. BUSY stays high while the bits are
//   stepped. DONE rises with the LED update and stays high until the next
//   accepted START or reset.
//
//   Optional macro: MANUAL_PAGE_EN adds the FLIP page-select input.
interface serial_adder_ctrl_if;
  logic [7:0] SW;
  logic       CIN;
  logic       START;
`ifdef MANUAL_PAGE_EN
  logic       FLIP;
`endif
  logic       BUSY;
  logic       DONE;
  logic [7:0] LED;
  logic [6:0] SLED0;
  logic [6:0] SLED1;
  logic [6:0] SLED2;
  logic [6:0] SLED3;
  logic [6:0] SLED4;
  logic [1:0] dbg_state;

  modport master (
`ifdef MANUAL_PAGE_EN
    output FLIP,
`endif
    output SW, CIN, START,
    input  BUSY, DONE, LED, SLED0, SLED1, SLED2, SLED3, SLED4, dbg_state
  );

  modport slave (
`ifdef MANUAL_PAGE_EN
    input  FLIP,
`endif
    input  SW, CIN, START,
    output BUSY, DONE, LED, SLED0, SLED1, SLED2, SLED3, SLED4, dbg_state
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial 4-bit adder. A single full-adder cell is stepped over
//   A=SW[3:0] and B=SW[7:4] (carry-in CIN), one bit per clock. The final
//   SUM/CARRY are latched to LED (LED[3:0]=SUM, LED[7:4]=carry-out of each
//   bit). The four digits show the bits of the selected page (SUM or CARRY)
//   and SLED4 shows the page code, or the busy code while adding.
//
// Ports
//   CLK   rising-edge clock
//   RSTN  asynchronous active-low reset
//   bus   serial_adder_ctrl_if.slave (SW, CIN, START in; BUSY, DONE, LED,
//         SLED0..SLED4, dbg_state out)
//
// Parameters
//   PAGE_TICKS  clocks per display page (2 .. 2^32-1)
//
// Configuration macro
//   MANUAL_PAGE_EN  page selected by bus.FLIP through one sync flop instead
//                   of the page timer.
module serial_adder_ctrl #(
  parameter int unsigned PAGE_TICKS = 32'd50000000
) (
  input  logic               CLK,
  input  logic               RSTN,
  serial_adder_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Active-low segment codes.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_SUM   = 7'b0100100;
  localparam logic [6:0] SEG_CARRY = 7'b0110001;
  localparam logic [6:0] SEG_BUSY  = 7'b1111110;

  logic [1:0] state;
  logic       start_prev;
  logic       start_pulse;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       carry;
  logic [1:0] idx;
  logic [3:0] sum_w;
  logic [3:0] carry_w;
  logic [7:0] led;
  logic       bit_s;
  logic       bit_co;
  logic       busy;
  logic       page;       // 0 = SUM page, 1 = CARRY page
  logic [3:0] page_bits;
  logic [6:0] sled_d [4];
  logic [6:0] sled4;

  assign start_pulse = bus.START & ~start_prev;
  assign busy        = (state == ST_RUN);

  // The one full-adder cell, applied to the bit selected by idx.
  always_comb begin
    bit_s  = op_a[idx] ^ op_b[idx] ^ carry;
    bit_co = (op_a[idx] & op_b[idx]) | (op_a[idx] & carry) | (op_b[idx] & carry);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
      op_a       <= 4'h0;
      op_b       <= 4'h0;
      carry      <= 1'b0;
      idx        <= 2'd0;
      sum_w      <= 4'h0;
      carry_w    <= 4'h0;
      led        <= 8'h00;
    end else begin
      start_prev <= bus.START;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_pulse) begin
            op_a    <= bus.SW[3:0];
            op_b    <= bus.SW[7:4];
            carry   <= bus.CIN;
            idx     <= 2'd0;
            sum_w   <= 4'h0;
            carry_w <= 4'h0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_w[idx]   <= bit_s;
          carry_w[idx] <= bit_co;
          carry        <= bit_co;
          idx          <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Bits 0..2 are already in the working registers; bit 3 is
            // merged in directly so LED updates on the same edge.
            led   <= {bit_co, carry_w[2:0], bit_s, sum_w[2:0]};
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MANUAL_PAGE_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      page <= 1'b0;
    end else begin
      page <= bus.FLIP;
    end
  end
`else
  logic [31:0] page_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      page_cnt <= 32'd0;
      page     <= 1'b0;
    end else if (page_cnt == PAGE_TICKS - 32'd1) begin
      page_cnt <= 32'd0;
      page     <= ~page;
    end else begin
      page_cnt <= page_cnt + 32'd1;
    end
  end
`endif

  // While adding, the digits show the working register of the current page;
  // unprocessed bits read 0 because the working registers clear at launch.
  always_comb begin
    if (busy) begin
      page_bits = page ? carry_w : sum_w;
    end else begin
      page_bits = page ? led[7:4] : led[3:0];
    end
  end

  // Registered display: lags LED/page by one clock.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 4; i++) begin
        sled_d[i] <= SEG_0;
      end
      sled4 <= SEG_SUM;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sled_d[i] <= page_bits[i] ? SEG_1 : SEG_0;
      end
      if (busy) begin
        sled4 <= SEG_BUSY;
      end else begin
        sled4 <= page ? SEG_CARRY : SEG_SUM;
      end
    end
  end

  assign bus.BUSY      = busy;
  assign bus.DONE      = (state == ST_DONE);
  assign bus.LED       = led;
  assign bus.SLED0     = sled_d[0];
  assign bus.SLED1     = sled_d[1];
  assign bus.SLED2     = sled_d[2];
  assign bus.SLED3     = sled_d[3];
  assign bus.SLED4     = sled4;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Testbench for serial_adder_ctrl with PAGE_TICKS=4.
module tb_serial_adder_ctrl;

  localparam int PT = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_SUM   = 7'b0100100;
  localparam logic [6:0] SEG_CARRY = 7'b0110001;
  localparam logic [6:0] SEG_BUSY  = 7'b1111110;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic RSTN = 1'b1;

  always #5 CLK = ~CLK;

  serial_adder_ctrl_if bus();

  serial_adder_ctrl #(.PAGE_TICKS(PT)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  logic       m_prev;
  logic       m_busy;
  logic       m_done;
  logic       m_page;
  int         m_pos;
  int         m_pcnt;
  logic [7:0] m_led;
  logic [7:0] m_res;
  logic [6:0] m_sled [5];

  // LED image of A + B + CIN: low nibble is the 4-bit sum, bit 4+i is the
  // carry out of bit position i (carry out of the (i+1)-bit partial sum).
  function automatic logic [7:0] add_result(input logic [7:0] sw, input logic cin);
    int a;
    int b;
    int m;
    logic [7:0] r;
    a = int'(sw[3:0]);
    b = int'(sw[7:4]);
    r[3:0] = 4'(a + b + int'(cin));
    for (int i = 0; i < 4; i++) begin
      m = (1 << (i + 1)) - 1;
      r[4 + i] = 1'((((a & m) + (b & m) + int'(cin)) >> (i + 1)) & 1);
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic v);
    return v ? SEG_1 : SEG_0;
  endfunction

  always @(posedge CLK or negedge RSTN) begin : model_blk
    logic [3:0] pb;
    logic       pulse;
    if (!RSTN) begin
      m_prev = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_page = 1'b0;
      m_pos  = 0;
      m_pcnt = 0;
      m_led  = 8'h00;
      m_res  = 8'h00;
      for (int i = 0; i < 4; i++) m_sled[i] = SEG_0;
      m_sled[4] = SEG_SUM;
      exp_q.delete();
    end else begin
      pulse = bus.START && !m_prev;
      // display reflects the situation just before this edge
      if (m_busy) begin
        pb = (m_page ? m_res[7:4] : m_res[3:0]) & 4'((1 << m_pos) - 1);
        m_sled[4] = SEG_BUSY;
      end else begin
        pb = m_page ? m_led[7:4] : m_led[3:0];
        m_sled[4] = m_page ? SEG_CARRY : SEG_SUM;
      end
      for (int i = 0; i < 4; i++) m_sled[i] = seg(pb[i]);
      if (m_busy) begin
        if (m_pos == 3) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_led  = m_res;
        end else begin
          m_pos = m_pos + 1;
        end
      end else if (pulse) begin
        m_res  = add_result(bus.SW, bus.CIN);
        exp_q.push_back(m_res);
        m_busy = 1'b1;
        m_done = 1'b0;
        m_pos  = 0;
      end
      m_prev = bus.START;
`ifdef MANUAL_PAGE_EN
      m_page = bus.FLIP;
`else
      if (m_pcnt == PT - 1) begin
        m_pcnt = 0;
        m_page = ~m_page;
      end else begin
        m_pcnt = m_pcnt + 1;
      end
`endif
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic done_q = 1'b0;

  always @(negedge CLK) begin : cmp_blk
    logic [7:0]  e;
    logic [44:0] got;
    logic [44:0] want;
    got  = {bus.BUSY, bus.DONE, bus.LED, bus.SLED4, bus.SLED3, bus.SLED2, bus.SLED1, bus.SLED0};
    want = {m_busy, m_done, m_led, m_sled[4], m_sled[3], m_sled[2], m_sled[1], m_sled[0]};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL cycle_compare t=%0t got busy/done/led/sled4..0=%b/%b/%h/%b got want %b/%b/%h/%b",
               $time, bus.BUSY, bus.DONE, bus.LED,
               {bus.SLED4, bus.SLED3, bus.SLED2, bus.SLED1, bus.SLED0},
               m_busy, m_done, m_led,
               {m_sled[4], m_sled[3], m_sled[2], m_sled[1], m_sled[0]});
    end
    if (bus.DONE && !done_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard t=%0t DONE rose with led=%h but no result expected", $time, bus.LED);
      end else begin
        e = exp_q.pop_front();
        if (bus.LED !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t got led=%h expected %h", $time, bus.LED, e);
        end
      end
    end
    done_q = bus.DONE;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(input string name, output int busy_n);
    int waited;
    busy_n = 0;
    waited = 0;
    while (bus.DONE !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      if (bus.BUSY === 1'b1) busy_n++;
      waited++;
    end
    if (bus.DONE !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: DONE=%b after %0d cycles, required 1", name, bus.DONE, waited);
    end
  endtask

  task automatic run_add(input logic [7:0] sw, input logic cin, input logic [7:0] exp,
                         input string name);
    int busy_n;
    bus.SW    = sw;
    bus.CIN   = cin;
    bus.START = 1'b0;
    step(1);
    bus.START = 1'b1;
    step(1);
    bus.START = 1'b0;
    check({name, "_launch"}, 32'({bus.BUSY, bus.DONE}), 32'b10);
    wait_done(name, busy_n);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd4);
    check({name, "_led"}, 32'(bus.LED), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_led"}, 32'(bus.LED), 32'h00);
    check({name, "_busy_done"}, 32'({bus.BUSY, bus.DONE}), 32'b00);
    check({name, "_digits"}, 32'({bus.SLED3, bus.SLED2, bus.SLED1, bus.SLED0}),
          32'({SEG_0, SEG_0, SEG_0, SEG_0}));
    check({name, "_sled4"}, 32'(bus.SLED4), 32'(SEG_SUM));
  endtask

  // ---------------- stimulus ----------------
  initial begin : main_blk
    int busy_n;
    int trans;
    logic [6:0] prev4;

    bus.SW    = 8'hFF;
    bus.CIN   = 1'b1;
    bus.START = 1'b1;
`ifdef MANUAL_PAGE_EN
    bus.FLIP  = 1'b0;
`endif
    #1 RSTN = 1'b0;
    step(3);
    check_reset_outputs("reset");
    check("model_pin_35", 32'(add_result(8'h35, 1'b0)), 32'h78);

    bus.START = 1'b0;
    bus.SW    = 8'h00;
    bus.CIN   = 1'b0;
    step(1);
    RSTN = 1'b1;
    step(2);

    // basic add, then paging on its result
    run_add(8'h35, 1'b0, 8'h78, "add_35");
`ifndef MANUAL_PAGE_EN
    trans = 0;
    prev4 = 7'h00;
    for (int i = 0; i < 17; i++) begin
      step(1);
      if (i > 0 && bus.SLED4 !== prev4) trans++;
      prev4 = bus.SLED4;
      if (bus.SLED4 === SEG_SUM) begin
        check("page_sum_digits", 32'({bus.SLED3, bus.SLED2, bus.SLED1, bus.SLED0}),
              32'({SEG_1, SEG_0, SEG_0, SEG_0}));
      end else if (bus.SLED4 === SEG_CARRY) begin
        check("page_carry_digits", 32'({bus.SLED3, bus.SLED2, bus.SLED1, bus.SLED0}),
              32'({SEG_0, SEG_1, SEG_1, SEG_1}));
      end else begin
        check("page_code", 32'(bus.SLED4), 32'(SEG_SUM));
      end
    end
    check("page_transitions", 32'(trans), 32'd4);
`endif

    // carry chain and CIN (each relaunches from DONE)
    run_add(8'h1F, 1'b0, 8'hF0, "add_1f");
    run_add(8'h00, 1'b1, 8'h01, "add_00_cin");
    run_add(8'hFF, 1'b1, 8'hFF, "add_ff_cin");

    // START held high: exactly one add
    bus.SW  = 8'h35;
    bus.CIN = 1'b0;
    busy_n  = 0;
    bus.START = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.BUSY === 1'b1) busy_n++;
    end
    bus.START = 1'b0;
    check("held_start_busy_cycles", 32'(busy_n), 32'd4);
    check("held_start_led", 32'(bus.LED), 32'h78);
    step(2);

    // pulse and operand change during RUN are ignored
    bus.SW  = 8'h1F;
    bus.CIN = 1'b0;
    bus.START = 1'b1;
    step(1);
    bus.START = 1'b0;
    step(1);
    bus.START = 1'b1;
    bus.SW    = 8'hFF;
    bus.CIN   = 1'b1;
    step(1);
    bus.START = 1'b0;
    wait_done("midrun", busy_n);
    check("midrun_led", 32'(bus.LED), 32'hF0);
    step(6);
    check("midrun_no_queue", 32'({bus.BUSY, bus.DONE}), 32'b01);

    // reset during RUN
    bus.SW  = 8'h35;
    bus.CIN = 1'b0;
    bus.START = 1'b1;
    step(1);
    bus.START = 1'b0;
    step(2);
    #1 RSTN = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    step(2);
    RSTN = 1'b1;
    step(1);
    run_add(8'h1F, 1'b0, 8'hF0, "after_reset");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.START = ($urandom_range(0, 2) == 0);
      bus.SW    = 8'($urandom);
      bus.CIN   = 1'($urandom_range(0, 1));
`ifdef MANUAL_PAGE_EN
      bus.FLIP  = 1'($urandom_range(0, 1));
`endif
      step(1);
    end
    bus.START = 1'b0;
    step(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequenced replacement for the combinational 4-bit sum/carry board block.
- A single 1-bit full-adder cell is stepped across the 4-bit operands A=SW[3:0] and B=SW[7:4], one bit per clock, under a START/BUSY/DONE handshake.
- Results are latched to LED[7:0].
- A page scheduler alternates the four 7-segment digits between the SUM page and the CARRY page, replacing the manual page switch.

Parameters:
- PAGE_TICKS, 50000000, CLK cycles per display page; legal range 2 to 2^32-1.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- SW  input  8  operands: A=SW[3:0], B=SW[7:4]; sampled only at operation start.
- CIN  input  1  carry into bit 0; sampled at operation start.
- START  input  1  synchronous request; rising edge (sampled low then high) launches an add.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  high from completion until the next accepted START or reset.
- LED  output  8  LED[3:0]=SUM[3:0], LED[7:4]=CARRY[3:0] (carry-out of bit i on LED[4+i]).
- SLED0..SLED3  output  7 each  digit i shows bit i of the displayed page.
- SLED4  output  7  page/status indicator.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State=IDLE; BUSY=0, DONE=0, LED=8'h00.
  - SLED0..3=0000001; SLED4=0100100; page=SUM; page counter=0; START history=0.
- Segment codes (active-low, fixed):
  - Bit 0 -> 0000001; bit 1 -> 1001111.
  - SUM page -> 0100100; CARRY page -> 0110001; busy -> 1111110.
- START edge detect: one register holds the previous START. start_pulse = START & ~prev. A held-high START yields exactly one pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start_pulse--> RUN. Same edge: latch A, B, CIN; idx=0; clear SUM/CARRY working registers.
  - RUN, one edge per bit: s=a[idx]^b[idx]^c; co=majority(a[idx],b[idx],c); SUM[idx]=s; CARRY[idx]=co; c=co; idx=idx+1.
  - RUN exits to DONE on the edge that processes idx=3.
  - DONE --start_pulse--> RUN. Relaunches with the same latching as IDLE; DONE drops on that edge.
- Timing:
  - Pulse sampled at edge k: BUSY=1 after k through after k+3; bit i is processed at edge k+1+i.
  - After edge k+4: BUSY=0, DONE=1, LED updated with the final SUM/CARRY.
  - Total latency is 5 edges from the first edge sampling START high.
  - LED holds its previous result during RUN and updates only on entry to DONE.
- Ignored inputs:
  - start_pulse during RUN is ignored and not queued.
  - SW/CIN changes after latching have no effect on the running add.
- Overflow: the final carry-out equals CARRY[3] (LED[7]). No separate flag.
- Page scheduler:
  - Free-running counter 0..PAGE_TICKS-1. On wrap to 0, page toggles SUM<->CARRY.
  - Runs in every FSM state.
- Display, registered (one-cycle lag vs LED/page):
  - BUSY=1: SLED4=1111110; SLED0..3 show the in-progress working register of the current page (unprocessed bits read 0).
  - BUSY=0: SLED4 shows the page code; SLED0..3 show LED bits of the selected page.
- Reset mid-RUN aborts immediately to reset values. The partial result is discarded.

Optional Feature:
- MANUAL_PAGE_EN defined:
  - Adds input port FLIP (1 bit); page = FLIP (0=SUM, 1=CARRY), passed through one sync flop.
  - PAGE_TICKS counter is not instantiated.
- MANUAL_PAGE_EN undefined: no FLIP port; timer-driven paging as above.

Test Plan:
- Reset: hold RSTN=0 with SW=8'hFF and START=1 -> LED=8'h00, BUSY=0, DONE=0, SLED0..3=0000001, SLED4=0100100.
- Basic add: SW=8'h35 (A=5, B=3), CIN=0, START pulse -> BUSY high exactly 4 cycles, then DONE=1, LED=8'h78 (SUM=1000, CARRY=0111).
- Carry chain and CIN:
  - SW=8'h1F, CIN=0 -> LED=8'hF0.
  - SW=8'h00, CIN=1 -> LED=8'h01.
  - SW=8'hFF, CIN=1 -> LED=8'hFF.
- Handshake: hold START high 20 cycles -> exactly one add. Pulse START again during RUN -> ignored. Change SW mid-RUN -> result unchanged. START in DONE -> new add, DONE drops next edge.
- Paging with PAGE_TICKS=4, after SW=8'h35 add:
  - SLED4 alternates 0100100/0110001 every 4 cycles.
  - SLED3..0 = 1001111,0000001,0000001,0000001 on the SUM page.
  - SLED3..0 = 0000001,1001111,1001111,1001111 on the CARRY page.
- Reset mid-RUN: assert RSTN=0 after 2 RUN cycles -> all outputs at reset values at once. After release, a new START completes with the correct result.
